rotary_value_controller: RTL and testbench
==========================================

# rotary_value_controller

Converts the one-cycle `rotary_left`/`rotary_right` pulses from the rotary encoder interface into a bounded numeric value with speed-dependent step size (acceleration). It also publishes each changed value to a downstream consumer over a valid/ready handshake. It sits between the encoder front-end and any setting register (volume, menu index, display parameter) in the board-level design.

## Interface
- `WIDTH`, 8: value width in bits.
- `MIN_VALUE`, 0: lowest legal value.
- `MAX_VALUE`, 255: highest legal value. Must be greater than `MIN_VALUE`.
- `INIT_VALUE`, 0: value after reset. Must lie within [`MIN_VALUE`, `MAX_VALUE`].
- `WRAP`, 0: 1 = wrap around at the limits; 0 = saturate at the limits.
- `ACCEL_WINDOW`, 1000: maximum gap, in cycles, between same-direction pulses that still counts as accelerating.
- `MAX_STEP`, 16: step ceiling. Must be a power of two and ≤ `MAX_VALUE - MIN_VALUE + 1`.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rotary_left`  in  1  one-cycle pulse: decrement.
- `rotary_right`  in  1  one-cycle pulse: increment.
- `load`  in  1  one-cycle request to force the value.
- `load_value`  in  WIDTH  value to force when `load` is high.
- `out_value`  out  WIDTH  current value.
- `out_valid`  out  1  `out_value` has changed and has not yet been accepted.
- `out_ready`  in  1  consumer accepts `out_value`.
- `at_min`  out  1  `out_value == MIN_VALUE`.
- `at_max`  out  1  `out_value == MAX_VALUE`.

## Operation
- Reset (while `reset == 0` at a clock edge):
  - `out_value = INIT_VALUE`, `out_valid = 0`.
  - `at_min`/`at_max` reflect `INIT_VALUE`.
  - FSM goes to IDLE, step = 1, gap counter = 0.
- Reset mid-operation discards any pending change and any acceleration state.
- Event priority per cycle: `load` first, then rotation. If `rotary_left` and `rotary_right` are high in the same cycle, both are ignored (no change).
- `load`:
  - Value becomes `load_value`, clamped to [`MIN_VALUE`, `MAX_VALUE`].
  - `out_valid` is set to 1.
  - FSM returns to IDLE with step = 1.
- Acceleration FSM, states IDLE and TRACK; `dir` register holds the last direction.
  - IDLE + pulse: apply step 1, record `dir`, clear gap counter, go to TRACK.
  - TRACK + pulse in the same `dir` with gap < `ACCEL_WINDOW`: double the step, capped at `MAX_STEP`, then apply the new step.
  - TRACK + pulse in the opposite direction: step = 1, apply it, update `dir`, clear gap counter.
  - TRACK, no pulse: gap counter increments. On reaching `ACCEL_WINDOW`, go to IDLE with step = 1.
- Step application: computed in `WIDTH+2`-bit arithmetic.
  - Saturate mode: clamp the result to [`MIN_VALUE`, `MAX_VALUE`].
  - Wrap mode: modulo over the range, e.g. `MAX_VALUE + 1` becomes `MIN_VALUE`, `MIN_VALUE - 2` becomes `MAX_VALUE - 1`.
- `out_valid`:
  - Set when an applied event changes the value.
  - A saturated pulse that leaves the value unchanged does not set it.
  - Cleared when `out_ready && out_valid` and no change happens in the same cycle.
  - If a change and acceptance coincide, `out_valid` stays 1 and carries the new value.
- The value keeps updating while `out_valid` is high and `out_ready` is low. Only the latest value is offered; intermediate values are dropped.

## Timing
- Latency: pulse or `load` at edge N; `out_value`, `out_valid`, `at_min`, `at_max` update at edge N+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `out_ready` may be high without `out_valid`; it has no effect in that case.
- Gap counter width: `$clog2(ACCEL_WINDOW+1)`. It saturates and does not roll over.
- Step doubling sequence: 1, 2, 4, … up to `MAX_STEP`. It takes effect on the pulse that qualifies, not on the following pulse.

## Structure
- Shared package `rotary_pkg`:
  - FSM state enum (IDLE, TRACK).
  - Direction enum (DIR_LEFT, DIR_RIGHT).
  - Helper function for the wrap/saturate range calculation.
- One natural sub-module: `rotary_accel_fsm`, which owns the state, `dir`, gap counter and step, and outputs `step` and `apply_dir`. The top level holds the value register, the handshake and the flags.

## Test plan
- Reset: defaults, `INIT_VALUE = 10`, hold `reset` low 2 cycles → `out_value = 10`, `out_valid = 0`, `at_min = 0`.
- Slow pulses: 3 `rotary_right` pulses spaced 2000 cycles apart, starting at 10 → values 11, 12, 13; `out_valid` rises each time; consumer accepts each.
- Acceleration: 6 `rotary_right` pulses spaced 10 cycles apart from 0, `MAX_STEP = 16` → values 1, 3, 7, 15, 31, 47. Then a `rotary_left` pulse → 46.
- Saturate: `WRAP = 0`, value 254, fast `rotary_right` pulses → 255, then stays 255 with no new `out_valid` after acceptance; `at_max = 1`.
- Wrap: `WRAP = 1`, range 0..9, value 9, single `rotary_right` → 0. A `rotary_left` after the gap expires → 9.
- Handshake and priority: hold `out_ready = 0` for 5 pulses → only the final value is presented, `out_valid` stays 1. Assert `load = 1` with `load_value = 300` (WIDTH 9) and `rotary_right = 1` in the same cycle → value = 255 (clamped), step resets to 1. Pulse plus `out_ready` in the same cycle → `out_valid` remains 1.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared types and the range-folding helper for the rotary value controller.
package rotary_pkg;

    // Acceleration tracker states
    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } accelState_t;

    // Direction of the most recent applied pulse
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } rotDir_t;

    // Bring an out-of-range candidate back into [lo, hi], either by clamping
    // or by wrapping. A single span correction is enough because the step
    // never exceeds the span.
    function automatic longint foldRange(
        input longint candidate,
        input longint lo,
        input longint hi,
        input bit     wrapMode
    );
        longint span;
        longint result;
        span   = hi - lo + 1;
        result = candidate;
        if (candidate > hi) begin
            result = wrapMode ? (candidate - span) : hi;
        end else if (candidate < lo) begin
            result = wrapMode ? (candidate + span) : lo;
        end
        return result;
    endfunction

endpackage

// File: rtl/rotary_accel_fsm.sv
// Acceleration tracker: owns state, direction, gap counter and step size.
// The step presented on 'step' is the one to apply for the pulse in this
// cycle, so a qualifying pulse already uses the doubled step.
module rotary_accel_fsm
    import rotary_pkg::*;
#(
    parameter int ACCEL_WINDOW = 1000,
    parameter int MAX_STEP     = 16,
    parameter int STEP_W       = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              rotary_left,
    input  logic              rotary_right,
    output logic              apply,
    output rotDir_t           apply_dir,
    output logic [STEP_W-1:0] step
);

    localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(ACCEL_WINDOW);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(ACCEL_WINDOW - 1);
    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEP);
    localparam logic [STEP_W-1:0] STEP_HALF = STEP_W'(MAX_STEP / 2);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    accelState_t       stateReg;
    rotDir_t           dirReg;
    logic [GAP_W-1:0]  gapCount;
    logic [STEP_W-1:0] stepReg;

    logic              pulse;
    rotDir_t           pulseDir;
    logic [STEP_W-1:0] stepNow;

    // Opposing pulses in one cycle cancel out and count as no pulse
    assign pulse    = rotary_left ^ rotary_right;
    assign pulseDir = rotary_right ? DIR_RIGHT : DIR_LEFT;

    // Step for a pulse arriving now: doubled only for a fast same-direction pulse
    always_comb begin
        stepNow = STEP_ONE;
        if (stateReg == TRACK && pulseDir == dirReg && gapCount < GAP_LIMIT) begin
            stepNow = (stepReg >= STEP_HALF) ? STEP_MAX : (stepReg << 1);
        end
    end

    assign apply     = pulse && !load;
    assign apply_dir = pulseDir;
    assign step      = stepNow;

    // State, direction, gap counter and step register; load forces a fresh start
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg <= IDLE;
            dirReg   <= DIR_RIGHT;
            gapCount <= '0;
            stepReg  <= STEP_ONE;
        end else if (load) begin
            stateReg <= IDLE;
            gapCount <= '0;
            stepReg  <= STEP_ONE;
        end else if (pulse) begin
            stateReg <= TRACK;
            dirReg   <= pulseDir;
            gapCount <= '0;
            stepReg  <= stepNow;
        end else if (stateReg == TRACK) begin
            if (gapCount != GAP_LIMIT) begin
                gapCount <= gapCount + 1'b1;
            end
            if (gapCount >= GAP_LAST) begin
                stateReg <= IDLE;
                stepReg  <= STEP_ONE;
            end
        end
    end

endmodule

// File: rtl/rotary_value_controller.sv
// Bounded value driven by rotary pulses with acceleration, published to a
// consumer over valid/ready. Only the latest value is ever offered.
module rotary_value_controller
    import rotary_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MIN_VALUE    = 0,
    parameter int MAX_VALUE    = 255,
    parameter int INIT_VALUE   = 0,
    parameter int WRAP         = 0,
    parameter int ACCEL_WINDOW = 1000,
    parameter int MAX_STEP     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rotary_left,
    input  logic             rotary_right,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             at_min,
    output logic             at_max
);

    localparam int STEP_W = WIDTH + 1;
    localparam int CALC_W = WIDTH + 2;
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VALUE);

    logic              apply;
    rotDir_t           applyDir;
    logic [STEP_W-1:0] step;

    logic signed [CALC_W-1:0] candidate;
    logic [WIDTH-1:0]         rotValue;
    logic [WIDTH-1:0]         loadClamped;
    logic [WIDTH-1:0]         valueNext;
    logic                     setValid;
    logic                     validNext;

    rotary_accel_fsm #(
        .ACCEL_WINDOW (ACCEL_WINDOW),
        .MAX_STEP     (MAX_STEP),
        .STEP_W       (STEP_W)
    ) accelFsm (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .rotary_left  (rotary_left),
        .rotary_right (rotary_right),
        .apply        (apply),
        .apply_dir    (applyDir),
        .step         (step)
    );

    // Candidate after stepping, folded back into range; two spare bits hold
    // the overshoot in either direction
    always_comb begin
        if (applyDir == DIR_RIGHT) begin
            candidate = signed'({2'b00, out_value}) + signed'({1'b0, step});
        end else begin
            candidate = signed'({2'b00, out_value}) - signed'({1'b0, step});
        end
        rotValue = WIDTH'(foldRange(longint'(candidate), longint'(MIN_VALUE),
                                    longint'(MAX_VALUE), WRAP != 0));
    end

    // Forced value is clamped into the legal range
    always_comb begin
        loadClamped = load_value;
        if (load_value < MIN_V) begin
            loadClamped = MIN_V;
        end else if (load_value > MAX_V) begin
            loadClamped = MAX_V;
        end
    end

    // Next value and valid: load wins over rotation; a real change keeps valid
    // high even when the consumer accepts in the same cycle
    always_comb begin
        valueNext = out_value;
        setValid  = 1'b0;
        if (load) begin
            valueNext = loadClamped;
            setValid  = 1'b1;
        end else if (apply) begin
            valueNext = rotValue;
            setValid  = (rotValue != out_value);
        end
        if (setValid) begin
            validNext = 1'b1;
        end else if (out_valid && out_ready) begin
            validNext = 1'b0;
        end else begin
            validNext = out_valid;
        end
    end

    // Registered outputs, flags derived from the value being stored
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_value <= INIT_V;
            out_valid <= 1'b0;
            at_min    <= (INIT_V == MIN_V);
            at_max    <= (INIT_V == MAX_V);
        end else begin
            out_value <= valueNext;
            out_valid <= validNext;
            at_min    <= (valueNext == MIN_V);
            at_max    <= (valueNext == MAX_V);
        end
    end

endmodule

// File: tb/tb_rotary_value_controller.sv
// Directed bench for rotary_value_controller with three parameterisations:
// A = 8-bit saturating with INIT 10, B = wrapping range 0..9, C = 9-bit
// saturating at 255. Expected values are queued when stimulus is driven and
// checked when the consumer accepts.
module tb_rotary_value_controller;

    logic clock = 1'b0;
    logic rstN  = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] leftIn  = '0;
    logic [2:0] rightIn = '0;
    logic [2:0] loadIn  = '0;
    logic [2:0] readyIn = '0;
    logic [7:0] loadA   = '0;
    logic [7:0] loadB   = '0;
    logic [8:0] loadC   = '0;

    logic [7:0] valA;
    logic [7:0] valB;
    logic [8:0] valC;
    logic [2:0] vld;
    logic [2:0] atMin;
    logic [2:0] atMax;

    int total = 0;
    int bad   = 0;
    int expQ[$];

    rotary_value_controller #(
        .WIDTH(8), .MIN_VALUE(0), .MAX_VALUE(255), .INIT_VALUE(10),
        .WRAP(0), .ACCEL_WINDOW(1000), .MAX_STEP(16)
    ) dutA (
        .clock(clock), .reset(rstN),
        .rotary_left(leftIn[0]), .rotary_right(rightIn[0]),
        .load(loadIn[0]), .load_value(loadA),
        .out_value(valA), .out_valid(vld[0]), .out_ready(readyIn[0]),
        .at_min(atMin[0]), .at_max(atMax[0])
    );

    rotary_value_controller #(
        .WIDTH(8), .MIN_VALUE(0), .MAX_VALUE(9), .INIT_VALUE(9),
        .WRAP(1), .ACCEL_WINDOW(20), .MAX_STEP(8)
    ) dutB (
        .clock(clock), .reset(rstN),
        .rotary_left(leftIn[1]), .rotary_right(rightIn[1]),
        .load(loadIn[1]), .load_value(loadB),
        .out_value(valB), .out_valid(vld[1]), .out_ready(readyIn[1]),
        .at_min(atMin[1]), .at_max(atMax[1])
    );

    rotary_value_controller #(
        .WIDTH(9), .MIN_VALUE(0), .MAX_VALUE(255), .INIT_VALUE(0),
        .WRAP(0), .ACCEL_WINDOW(1000), .MAX_STEP(16)
    ) dutC (
        .clock(clock), .reset(rstN),
        .rotary_left(leftIn[2]), .rotary_right(rightIn[2]),
        .load(loadIn[2]), .load_value(loadC),
        .out_value(valC), .out_valid(vld[2]), .out_ready(readyIn[2]),
        .at_min(atMin[2]), .at_max(atMax[2])
    );

    function automatic int curVal(input int d);
        case (d)
            0:       return int'(valA);
            1:       return int'(valB);
            default: return int'(valC);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One-cycle stimulus; outputs are valid on return (1 time unit after the edge)
    task automatic drive(input int d, input bit l, input bit r,
                         input bit ld, input int lv, input bit rdy);
        @(posedge clock); #1;
        leftIn[d]  = l;
        rightIn[d] = r;
        loadIn[d]  = ld;
        readyIn[d] = rdy;
        case (d)
            0:       loadA = 8'(lv);
            1:       loadB = 8'(lv);
            default: loadC = 9'(lv);
        endcase
        @(posedge clock); #1;
        leftIn[d]  = 1'b0;
        rightIn[d] = 1'b0;
        loadIn[d]  = 1'b0;
        readyIn[d] = 1'b0;
    endtask

    // Consumer side: wait (bounded) for valid, accept, compare against queue head
    task automatic collect(input int d, input string tag);
        int expv;
        readyIn[d] = 1'b1;
        for (int i = 0; i < 50 && !vld[d]; i++) begin
            @(posedge clock); #1;
        end
        expv = (expQ.size() > 0) ? expQ.pop_front() : -1;
        if (!vld[d]) begin
            chk({tag, "_timeout"}, int'(vld[d]), 1);
        end else begin
            $display("txn %s dut=%0d value=%0d expected=%0d", tag, d, curVal(d), expv);
            chk(tag, curVal(d), expv);
        end
        @(posedge clock); #1;
        readyIn[d] = 1'b0;
        chk({tag, "_accepted"}, int'(vld[d]), 0);
    endtask

    initial begin
        // Reset held low for two edges
        rstN = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rstN = 1'b1;
        chk("rst_valA", int'(valA), 10);
        chk("rst_vldA", int'(vld[0]), 0);
        chk("rst_minA", int'(atMin[0]), 0);
        chk("rst_maxA", int'(atMax[0]), 0);
        chk("rst_valB", int'(valB), 9);
        chk("rst_maxB", int'(atMax[1]), 1);
        chk("rst_minC", int'(atMin[2]), 1);

        // Slow pulses: each one restarts at step 1
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            expQ.push_back(10 + k);
            collect(0, "slow");
            repeat (2000) @(posedge clock);
            #1;
        end

        // Acceleration from 0
        drive(0, 0, 0, 1, 0, 0);
        expQ.push_back(0);
        collect(0, "load0");
        chk("accel_min", int'(atMin[0]), 1);
        begin
            int accelExp[6] = '{1, 3, 7, 15, 31, 47};
            for (int k = 0; k < 6; k++) begin
                drive(0, 0, 1, 0, 0, 0);
                expQ.push_back(accelExp[k]);
                collect(0, "accel");
                repeat (5) @(posedge clock);
                #1;
            end
        end
        drive(0, 1, 0, 0, 0, 0);
        expQ.push_back(46);
        collect(0, "reverse");

        // Saturation at the top
        drive(0, 0, 0, 1, 254, 0);
        expQ.push_back(254);
        collect(0, "load254");
        drive(0, 0, 1, 0, 0, 0);
        expQ.push_back(255);
        collect(0, "sat_first");
        chk("sat_atmax", int'(atMax[0]), 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk("sat_novalid", int'(vld[0]), 0);
            chk("sat_value", int'(valA), 255);
        end

        // Reset mid-operation discards a pending change
        drive(0, 1, 0, 0, 0, 0);
        chk("pend_valid", int'(vld[0]), 1);
        chk("pend_value", int'(valA), 254);
        @(posedge clock); #1;
        rstN = 1'b0;
        @(posedge clock); #1;
        rstN = 1'b1;
        chk("midrst_value", int'(valA), 10);
        chk("midrst_valid", int'(vld[0]), 0);

        // Wrap mode, range 0..9
        drive(1, 0, 1, 0, 0, 0);
        expQ.push_back(0);
        collect(1, "wrap_up");
        chk("wrap_atmin", int'(atMin[1]), 1);
        repeat (30) @(posedge clock);
        #1;
        drive(1, 1, 0, 0, 0, 0);
        expQ.push_back(9);
        collect(1, "wrap_down");
        drive(1, 0, 0, 1, 1, 0);
        expQ.push_back(1);
        collect(1, "wrap_load1");
        drive(1, 1, 0, 0, 0, 0);
        expQ.push_back(0);
        collect(1, "wrap_to0");
        drive(1, 1, 0, 0, 0, 0);
        expQ.push_back(8);
        collect(1, "wrap_minus2");

        // Backpressure: only the latest value is offered
        for (int k = 0; k < 5; k++) begin
            drive(2, 0, 1, 0, 0, 0);
            chk("bp_valid", int'(vld[2]), 1);
            repeat (3) @(posedge clock);
            #1;
        end
        expQ.push_back(31);
        collect(2, "bp_latest");

        // Load beats rotation, out-of-range load is clamped
        drive(2, 0, 1, 1, 300, 0);
        expQ.push_back(255);
        collect(2, "load_clamp");
        chk("load_atmax", int'(atMax[2]), 1);
        drive(2, 1, 0, 0, 0, 0);
        expQ.push_back(254);
        collect(2, "after_load");

        // Change coinciding with acceptance keeps valid high with the new value
        drive(2, 1, 0, 0, 0, 0);
        chk("pre_accept_value", int'(valC), 252);
        drive(2, 1, 0, 0, 0, 1);
        chk("coincide_valid", int'(vld[2]), 1);
        expQ.push_back(248);
        collect(2, "coincide");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
